// File: rtl/mem_pkg.sv
// Shared opcodes, FSM encoding and sizing
// for the data-memory load/store unit.
package mem_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam int MEM_WORDS_DEF = 1000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic logic op_is_load(
    input logic [5:0] op
  );
    return (op == OP_LB)  || (op == OP_LH) ||
           (op == OP_LW)  || (op == OP_LBU) ||
           (op == OP_LHU);
  endfunction

  function automatic logic op_is_store(
    input logic [5:0] op
  );
    return (op == OP_SB) || (op == OP_SH) ||
           (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake between the
// datapath and the load/store unit.
interface mem_access_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid,
    output req_op,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err
  );

endinterface

// File: rtl/mem_access_unit_byte_lane_align.sv
// Big-endian lane extract/extend for loads,
// lane merge for sub-word stores, misalign detect.
module byte_lane_align
  import mem_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] mword,
  output logic        misalign
);

  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  b;
  logic [15:0] h;

  // byte 0 sits in the top lane, so shift by 8*(3-addr)
  always_comb begin
    bsh = {~addr, 3'b000};
    hsh = {~addr[1], 4'b0000};
    b   = 8'(rword >> bsh);
    h   = 16'(rword >> hsh);
  end

  always_comb begin
    ldata    = '0;
    mword    = rword;
    misalign = 1'b0;
    unique case (1'b1)
      op == OP_LB:
        ldata = {{24{b[7]}}, b};
      op == OP_LBU:
        ldata = {24'b0, b};
      op == OP_LH: begin
        ldata    = {{16{h[15]}}, h};
        misalign = addr[0];
      end
      op == OP_LHU: begin
        ldata    = {16'b0, h};
        misalign = addr[0];
      end
      op == OP_LW: begin
        ldata    = rword;
        misalign = |addr;
      end
      op == OP_SB:
        mword = (rword & ~(32'h0000_00FF << bsh))
              | (32'(wdata[7:0]) << bsh);
      op == OP_SH: begin
        mword = (rword & ~(32'h0000_FFFF << hsh))
              | (32'(wdata[15:0]) << hsh);
        misalign = addr[0];
      end
      op == OP_SW: begin
        mword    = wdata;
        misalign = |addr;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: one request per handshake,
// read-modify-write for sub-word stores.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  mem_access_unit_if.slave  bus,
  output logic [31:0]       Address,
  output logic [31:0]       Write_data,
  output logic              Mem_read,
  output logic              Mem_write,
  input  logic [31:0]       Read_data
);

  state_t      state;
  logic [5:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        idle;
  logic [5:0]  al_op;
  logic [1:0]  al_addr;
  logic [31:0] al_wdata;
  logic [31:0] ldata;
  logic [31:0] mword;
  logic        misalign;
  logic        known;
  logic        range_err;
  logic        req_err;

  assign idle          = (state == ST_IDLE);
  assign bus.req_ready = idle;

  // In IDLE the aligner vets the live request;
  // afterwards it works on the latched copy.
  always_comb begin
    al_op     = idle ? bus.req_op : op_q;
    al_addr   = idle ? bus.req_addr[1:0]
                     : addr_q[1:0];
    al_wdata  = wdata_q;
    known     = op_is_load(bus.req_op) ||
                op_is_store(bus.req_op);
    range_err = {2'b00, bus.req_addr[31:2]}
                >= 32'(MEM_WORDS);
    req_err   = !known || misalign || range_err;
  end

  byte_lane_align u_align (
    .op       (al_op),
    .addr     (al_addr),
    .rword    (Read_data),
    .wdata    (al_wdata),
    .ldata    (ldata),
    .mword    (mword),
    .misalign (misalign)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= ST_IDLE;
      op_q           <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
      Mem_read       <= 1'b0;
      Mem_write      <= 1'b0;
      Address        <= '0;
      Write_data     <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      Mem_read       <= 1'b0;
      Mem_write      <= 1'b0;
      Address        <= '0;
      Write_data     <= '0;
      unique case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            op_q    <= bus.req_op;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            if (req_err) begin
              state          <= ST_DONE;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
            end else if (bus.req_op == OP_SW) begin
              state      <= ST_WR;
              Mem_write  <= 1'b1;
              Address    <= {2'b00, bus.req_addr[31:2]};
              Write_data <= bus.req_wdata;
            end else begin
              state    <= ST_RD;
              Mem_read <= 1'b1;
              Address  <= {2'b00, bus.req_addr[31:2]};
            end
          end
        end
        ST_RD: begin
          state <= ST_CAP;
        end
        ST_CAP: begin
          if (op_is_load(op_q)) begin
            state          <= ST_DONE;
            bus.resp_rdata <= ldata;
            bus.resp_valid <= 1'b1;
          end else begin
            state      <= ST_WR;
            Mem_write  <= 1'b1;
            Address    <= {2'b00, addr_q[31:2]};
            Write_data <= mword;
          end
        end
        ST_WR: begin
          state          <= ST_DONE;
          bus.resp_valid <= 1'b1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator between the MIPS datapath and the word-addressed data memory. It accepts one byte-addressed load or store per handshake and drives the memory's Address/Write_data/Mem_read/Mem_write. It returns sign- or zero-extended load data and performs read-modify-write for byte and halfword stores. Access is big-endian, and the unit flags misaligned or out-of-range accesses instead of touching memory.

## Interface
Parameters:
- MEM_WORDS, 1000, number of 32-bit words in the data memory; valid word index is 0..MEM_WORDS-1.

Ports:
- Clk  in  1  system clock; all state changes on posedge.
- Reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; a request is accepted on a posedge where req_valid & req_ready.
- req_op  in  6  MIPS opcode: LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the byte/half is taken from the low bits.
- resp_valid  out  1  one-cycle pulse at completion of every accepted request.
- resp_rdata  out  32  extended load data; valid with resp_valid for loads, held until the next load completes.
- resp_err  out  1  valid with resp_valid; 1 = misaligned, out of range, or unsupported opcode.
- Address  out  32  word index to memory: req_addr[31:2].
- Write_data  out  32  word to memory.
- Mem_read  out  1  memory read strobe.
- Mem_write  out  1  memory write strobe.
- Read_data  in  32  memory read data; valid in the cycle after a Mem_read cycle.

## Operation
- States: IDLE, RD, CAP, WR, DONE. req_ready = (state==IDLE).
- IDLE: on accept, latch op, addr, and wdata. Then check:
  - Error (unsupported op, LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0, addr[31:2] >= MEM_WORDS): go to DONE with err=1. No memory strobe.
  - Loads and SB/SH: go to RD.
  - SW: go to WR.
- RD: Mem_read=1, Address=addr[31:2]; go to CAP.
- CAP: Read_data is valid in this state.
  - Loads: extract the lane and register it into resp_rdata. LB/LH sign-extend; LBU/LHU zero-extend.
  - SB/SH: register merged word = Read_data with the addressed lane replaced by wdata[7:0]/[15:0]; go to WR.
  - Loads go to DONE.
- WR: Mem_write=1, Address=addr[31:2], Write_data = wdata (SW) or merged word; go to DONE.
- DONE: resp_valid=1, resp_err as decided; go to IDLE.
- Lane map (big-endian):
  - Byte at addr[1:0]=0 is [31:24], 1 is [23:16], 2 is [15:8], 3 is [7:0].
  - Half at addr[1]=0 is [31:16], addr[1]=1 is [15:0].
- Mem_read and Mem_write are never both 1. Both are 0 outside RD/WR. Address and Write_data are 0 in IDLE.
- Errored loads leave resp_rdata unchanged.

## Timing
- Reset values: state IDLE, req_ready=1 (after reset deasserts), resp_valid=0, resp_err=0, resp_rdata=0, Mem_read=0, Mem_write=0, Address=0, Write_data=0.
- Latency from the accept edge to the resp_valid cycle:
  - Load: 3 cycles.
  - SW: 2 cycles.
  - SB/SH: 4 cycles.
  - Error: 1 cycle.
- No request is accepted while busy; the next accept is possible in the cycle after DONE. Back-to-back throughput for LW is one request per 4 cycles.
- req_* may change freely after the accept edge; all later behaviour uses the latched copies.
- Reset mid-operation: the next state is IDLE, strobes drop in the following cycle, and no resp_valid is issued for the aborted request. A WR cycle already sampled by memory is not undone.
- Reset concurrent with req_valid: the request is not accepted.

## Structure
- Shared package mem_pkg holds:
  - The opcode constants (OP_LB … OP_SW).
  - The state encoding (ST_IDLE, ST_RD, ST_CAP, ST_WR, ST_DONE).
  - The default MEM_WORDS.
- One combinational sub-module, byte_lane_align, with inputs op, addr[1:0], rword, and wdata. Outputs:
  - Extended load data.
  - Merged store word.
  - Misalign flag.

## Test plan
- Preload word 4 = 0x8123_45F6. LB at addr 0x13 → resp_rdata 0xFFFF_FFF6, err 0. LBU at 0x10 → 0x0000_0081. LH at 0x10 → 0xFFFF_8123. Each arrives 3 cycles after accept, with exactly one Mem_read cycle.
- SW 0xDEAD_BEEF at 0x20 → a single Mem_write cycle with Address 8, resp 2 cycles after accept. A following LW at 0x20 → 0xDEAD_BEEF.
- After that, SB 0x0000_0055 at 0x21 → RD then WR. Memory word 8 = 0xDE55_BEEF. SH 0x1234 at 0x22 → 0xDE55_1234.
- LW at 0x06, SH at 0x01, LW at 4*MEM_WORDS, and opcode 000000 → each gives resp_err=1 in 1 cycle, no Mem_read/Mem_write, and resp_rdata unchanged.
- Assert Reset in the CAP cycle of an SB → IDLE next cycle, no resp_valid, memory word unchanged. A new LW is accepted right after reset deasserts.
- Hold req_valid high continuously with alternating LW/SW → req_ready and accept only in IDLE. Exactly one resp_valid per accept, and Mem_read and Mem_write are never high together.
